// File: rtl/fp_add_pipe.sv
// fp_add_pipe: fully pipelined floating-point adder/subtractor with
// round-to-nearest-even, flush-to-zero for denormals and exception flags.
//
// Ports:
//   Clock        rising-edge clock
//   Reset        synchronous, active-high; clears every valid bit and outputs
//   Op1, Op2     operands {sign, exponent, mantissa}
//   Sub          1: Result = Op1 - Op2, 0: Result = Op1 + Op2
//   InputValid   operation present this cycle
//   Result       packed result, held while ResultValid is low
//   ResultValid  one-cycle strobe per accepted operation
//   Flags        {invalid, overflow, underflow, inexact}, valid with ResultValid
//
// Handshake: there is no ready. An operation is accepted on every rising edge
// where InputValid=1 and Reset=0. Its result appears with ResultValid=1
// exactly 4 edges later. Results leave in issue order, one per cycle.
//
// Pipeline: capture -> s1 unpack/swap -> s2 align/add -> s3 normalise
//           -> output register (round/pack).
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [W-1:0] Op1,
  input  logic [W-1:0] Op2,
  input  logic         Sub,
  input  logic         InputValid,
  output logic [W-1:0] Result,
  output logic         ResultValid,
  output logic [3:0]   Flags
);

  localparam int SW  = MAN_W + 4;                  // {hidden, man, G, R, S}
  localparam int LZW = $clog2(SW + 1);
  // Signed working exponent: holds 2^EXP_W and -(SW) without wrapping.
  localparam int XW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [XW-1:0] EMAX_X = $signed({{(XW-EXP_W){1'b0}}, EMAX});
  localparam logic signed [XW-1:0] ONE_X  = $signed({{(XW-1){1'b0}}, 1'b1});

  // ---------------- capture ----------------
  logic         v0;
  logic [W-1:0] x0, y0;

  always_ff @(posedge Clock) begin
    if (Reset) v0 <= 1'b0;
    else       v0 <= InputValid;
    if (InputValid) begin
      x0 <= Op1;
      y0 <= {Op2[W-1] ^ Sub, Op2[W-2:0]};   // subtraction folded into sign
    end
  end

  // ---------------- stage 1: classify, swap ----------------
  logic             xs, ys, x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, swap;
  logic [EXP_W-1:0] xe, ye, a_e, b_e;
  logic [MAN_W-1:0] xm, ym, xm_eff, ym_eff, a_m, b_m;
  logic             a_s;
  logic             spc_d;
  logic [W-1:0]     spc_res_d;
  logic [3:0]       spc_flg_d;

  assign xs = x0[W-1];
  assign ys = y0[W-1];
  assign xe = x0[W-2:MAN_W];
  assign ye = y0[W-2:MAN_W];
  assign xm = x0[MAN_W-1:0];
  assign ym = y0[MAN_W-1:0];
  // Exponent 0 covers both zero and denormal; denormals are flushed.
  assign x_zero = (xe == '0);
  assign y_zero = (ye == '0);
  assign x_inf  = (xe == EMAX) && (xm == '0);
  assign y_inf  = (ye == EMAX) && (ym == '0);
  assign x_nan  = (xe == EMAX) && (xm != '0);
  assign y_nan  = (ye == EMAX) && (ym != '0);
  assign xm_eff = x_zero ? '0 : xm;
  assign ym_eff = y_zero ? '0 : ym;
  assign swap   = {ye, ym_eff} > {xe, xm_eff};
  assign a_s    = swap ? ys : xs;
  assign a_e    = swap ? ye : xe;
  assign b_e    = swap ? xe : ye;
  assign a_m    = swap ? ym_eff : xm_eff;
  assign b_m    = swap ? xm_eff : ym_eff;

  // Special results bypass the arithmetic path and ride down the pipe.
  always_comb begin
    spc_d     = 1'b0;
    spc_res_d = '0;
    spc_flg_d = 4'b0000;
    if (x_nan || y_nan) begin
      spc_d     = 1'b1;
      spc_res_d = QNAN;
    end else if (x_inf && y_inf && (xs != ys)) begin
      spc_d     = 1'b1;
      spc_res_d = QNAN;
      spc_flg_d = 4'b1000;
    end else if (x_inf || y_inf || x_zero || y_zero) begin
      spc_d = 1'b1;
      // The inf or the nonzero operand always sorts to A.
      if (x_zero && y_zero) spc_res_d = {xs & ys, {(W-1){1'b0}}};
      else                  spc_res_d = {a_s, a_e, a_m};
    end
  end

  logic             v1, s1_sign, s1_sub, s1_spc;
  logic [EXP_W-1:0] s1_exp, s1_d;
  logic [MAN_W-1:0] s1_ma, s1_mb;
  logic [W-1:0]     s1_res;
  logic [3:0]       s1_flg;

  always_ff @(posedge Clock) begin
    if (Reset) v1 <= 1'b0;
    else       v1 <= v0;
    s1_sign <= a_s;
    s1_sub  <= xs ^ ys;
    s1_exp  <= a_e;
    s1_d    <= a_e - b_e;
    s1_ma   <= a_m;
    s1_mb   <= b_m;
    s1_spc  <= spc_d;
    s1_res  <= spc_res_d;
    s1_flg  <= spc_flg_d;
  end

  // ---------------- stage 2: align, add ----------------
  logic [SW-1:0] sig_a, sig_b, b_al, lost_mask;
  logic [SW:0]   sum_d;

  assign sig_a = {1'b1, s1_ma, 3'b000};
  assign sig_b = {1'b1, s1_mb, 3'b000};

  always_comb begin
    lost_mask = ~({SW{1'b1}} << s1_d);
    if (int'(s1_d) >= MAN_W + 3)
      b_al = {{(SW-1){1'b0}}, 1'b1};          // B survives only as sticky
    else
      b_al = (sig_b >> s1_d) | {{(SW-1){1'b0}}, |(sig_b & lost_mask)};
    if (s1_sub) sum_d = {1'b0, sig_a} - {1'b0, b_al};
    else        sum_d = {1'b0, sig_a} + {1'b0, b_al};
  end

  logic             v2, s2_sign, s2_spc;
  logic [EXP_W-1:0] s2_exp;
  logic [SW:0]      s2_sum;
  logic [W-1:0]     s2_res;
  logic [3:0]       s2_flg;

  always_ff @(posedge Clock) begin
    if (Reset) v2 <= 1'b0;
    else       v2 <= v1;
    s2_sign <= s1_sign;
    s2_exp  <= s1_exp;
    s2_sum  <= sum_d;
    s2_spc  <= s1_spc;
    s2_res  <= s1_res;
    s2_flg  <= s1_flg;
  end

  // ---------------- stage 3: normalise ----------------
  logic [LZW-1:0]         lz;
  logic [SW-1:0]          norm_d;
  logic signed [XW-1:0]   exp_in, exp_n_d;

  assign exp_in = $signed({{(XW-EXP_W){1'b0}}, s2_exp});

  always_comb begin
    // Ascending scan: the highest set bit is the last one written.
    lz = LZW'(SW);
    for (int i = 0; i < SW; i++)
      if (s2_sum[i]) lz = LZW'(SW - 1 - i);
    if (s2_sum[SW]) begin
      norm_d  = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
      exp_n_d = exp_in + ONE_X;
    end else begin
      norm_d  = s2_sum[SW-1:0] << lz;
      exp_n_d = exp_in - $signed({{(XW-LZW){1'b0}}, lz});
    end
  end

  logic                 v3, s3_sign, s3_zero, s3_spc;
  logic signed [XW-1:0] s3_exp;
  logic [SW-1:0]        s3_n;
  logic [W-1:0]         s3_res;
  logic [3:0]           s3_flg;

  always_ff @(posedge Clock) begin
    if (Reset) v3 <= 1'b0;
    else       v3 <= v2;
    s3_sign <= s2_sign;
    s3_zero <= (s2_sum == '0);
    s3_exp  <= exp_n_d;
    s3_n    <= norm_d;
    s3_spc  <= s2_spc;
    s3_res  <= s2_res;
    s3_flg  <= s2_flg;
  end

  // ---------------- stage 4: round, pack ----------------
  logic                 g, r, st, lsb, inc;
  logic [MAN_W+1:0]     rnd;
  logic [MAN_W-1:0]     man_f;
  logic signed [XW-1:0] exp_f;
  logic [W-1:0]         res_d;
  logic [3:0]           flg_d;

  assign lsb = s3_n[3];
  assign g   = s3_n[2];
  assign r   = s3_n[1];
  assign st  = s3_n[0];
  assign inc = g & (r | st | lsb);
  assign rnd = {1'b0, s3_n[SW-1:3]} + {{(MAN_W+1){1'b0}}, inc};

  always_comb begin
    if (rnd[MAN_W+1]) begin
      man_f = rnd[MAN_W:1];
      exp_f = s3_exp + ONE_X;
    end else begin
      man_f = rnd[MAN_W-1:0];
      exp_f = s3_exp;
    end
    res_d = {s3_sign, exp_f[EXP_W-1:0], man_f};
    flg_d = {3'b000, g | r | st};
    if (s3_spc) begin
      res_d = s3_res;
      flg_d = s3_flg;
    end else if (s3_zero) begin
      res_d = '0;                               // exact cancellation is +0
      flg_d = 4'b0000;
    end else if (exp_f >= EMAX_X) begin
      res_d = {s3_sign, EMAX, {MAN_W{1'b0}}};
      flg_d = 4'b0101;
    end else if (exp_f[XW-1] || (exp_f == '0)) begin
      res_d = {s3_sign, {(W-1){1'b0}}};
      flg_d = 4'b0011;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ResultValid <= 1'b0;
      Result      <= '0;
      Flags       <= 4'b0000;
    end else begin
      ResultValid <= v3;
      if (v3) begin
        Result <= res_d;
        Flags  <= flg_d;
      end
    end
  end

endmodule
